reg_load_arbiter: RTL and testbench

//   Round-robin write arbiter for the 8-bit register bank. Up to NUM_REQ

---
 rtl/reg_load_arbiter.sv | 97 +++++++++
 tb/tb_reg_load_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// Round-robin write arbiter for the register bank: grants one requester per
// cycle, drives the shared write bus and the one-hot register load strobe.
module reg_load_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*SEL_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REGS-1:0]       load_en,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      addr_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [NUM_REQ-1:0] eligible_c;
  logic [SEL_W-1:0]  addr_arr_c [NUM_REQ];
  logic [DATA_W-1:0] data_arr_c [NUM_REQ];
  logic              win_vld_c;
  logic [PTR_W-1:0]  win_idx_c;
  logic [SEL_W-1:0]  win_addr_c;
  logic              addr_ok_c;
  logic [NUM_REQ-1:0]  grant_c;
  logic [NUM_REGS-1:0] load_c;
  logic [PTR_W-1:0]  ptr_nxt_c;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return PTR_W'(sum % int'(NUM_REQ));
  endfunction

  // A requester granted last cycle is masked so it cannot write twice.
  assign eligible_c = req & ~grant;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      addr_arr_c[i] = req_addr[i*SEL_W +: SEL_W];
      data_arr_c[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan downward from the farthest offset so the nearest eligible index to ptr wins.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      if (eligible_c[rr_idx(ptr, off)]) begin
        win_vld_c = 1'b1;
        win_idx_c = rr_idx(ptr, off);
      end
    end
  end

  always_comb begin
    win_addr_c = addr_arr_c[win_idx_c];
    addr_ok_c  = 32'(win_addr_c) < NUM_REGS;
    ptr_nxt_c  = rr_idx(win_idx_c, 1);
    grant_c    = '0;
    load_c     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_c[i] = win_vld_c && (32'(win_idx_c) == i);
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      load_c[r] = win_vld_c && (32'(win_addr_c) == r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant    <= '0;
      load_en  <= '0;
      bus_data <= '0;
      addr_err <= 1'b0;
    end else if (win_vld_c && !hold) begin
      ptr      <= ptr_nxt_c;
      grant    <= grant_c;
      load_en  <= load_c;
      bus_data <= data_arr_c[win_idx_c];
      addr_err <= !addr_ok_c;
    end else begin
      grant    <= '0;
      load_en  <= '0;
      addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Self-checking bench for reg_load_arbiter: directed vector table, async reset
// sequence, then random traffic against a behavioural model.
module tb_reg_load_arbiter;

  localparam int unsigned NQ = 4;
  localparam int unsigned NR = 6;
  localparam int unsigned SW = 3;
  localparam int unsigned DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hold;
  logic [NQ-1:0]     req;
  logic [NQ*SW-1:0]  req_addr;
  logic [NQ*DW-1:0]  req_data;
  logic [NQ-1:0]     grant;
  logic [NR-1:0]     load_en;
  logic [DW-1:0]     bus_data;
  logic              addr_err;

  reg_load_arbiter #(.NUM_REQ(NQ), .NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req(req), .req_addr(req_addr),
    .req_data(req_data), .grant(grant), .load_en(load_en), .bus_data(bus_data),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        h;
    logic [3:0]  r;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  eg;
    logic [5:0]  el;
    logic [7:0]  eb;
    logic        ee;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  logic [3:0] m_grant;
  logic [5:0] m_load;
  logic [7:0] m_bus;
  logic       m_err;

  function automatic vec_t mk(input logic h, input logic [3:0] r, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] eg, input logic [5:0] el,
                              input logic [7:0] eb, input logic ee);
    vec_t v;
    v.h = h; v.r = r; v.a = a; v.d = d; v.eg = eg; v.el = el; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_grant = '0; m_load = '0; m_bus = '0; m_err = 1'b0;
  endtask

  // Rules: first eligible requester from ptr round the ring; address beyond bank only flags.
  task automatic model_step(input logic h, input logic [3:0] r, input logic [11:0] a, input logic [31:0] d);
    int k;
    int ad;
    k = -1;
    for (int o = 0; o < int'(NQ); o++) begin
      int i;
      i = (m_ptr + o) % int'(NQ);
      if (k < 0 && r[i] && !m_grant[i]) k = i;
    end
    if (h || k < 0) begin
      m_grant = '0; m_load = '0; m_err = 1'b0;
    end else begin
      ad = int'((a >> (3 * k)) & 12'h7);
      m_grant = 4'(1 << k);
      m_bus   = 8'((d >> (8 * k)) & 32'hFF);
      if (ad < int'(NR)) begin
        m_load = 6'(1 << ad); m_err = 1'b0;
      end else begin
        m_load = '0; m_err = 1'b1;
      end
      m_ptr = (k + 1) % int'(NQ);
    end
  endtask

  task automatic cycle(input logic h, input logic [3:0] r, input logic [11:0] a, input logic [31:0] d);
    hold = h; req = r; req_addr = a; req_data = d;
    model_step(h, r, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] eg,
                           input logic [5:0] el, input logic [7:0] eb, input logic ee);
    check({tag, ".grant"},    idx, 32'(grant),    32'(eg));
    check({tag, ".load_en"},  idx, 32'(load_en),  32'(el));
    check({tag, ".bus_data"}, idx, 32'(bus_data), 32'(eb));
    check({tag, ".addr_err"}, idx, 32'(addr_err), 32'(ee));
  endtask

  initial begin
    logic [11:0] rr_a;
    logic [31:0] rr_d;
    rr_a = 12'o3210;
    rr_d = 32'h13121110;

    // single write, re-request masked, second write after gap
    tbl.push_back(mk(0, 4'b0001, 12'o0005, 32'h000000A7, 4'b0001, 6'h20, 8'hA7, 0));
    tbl.push_back(mk(0, 4'b0001, 12'o0005, 32'h000000A7, 4'b0000, 6'h00, 8'hA7, 0));
    tbl.push_back(mk(0, 4'b0001, 12'o0005, 32'h000000A7, 4'b0001, 6'h20, 8'hA7, 0));
    tbl.push_back(mk(0, 4'b0000, 12'o0005, 32'h000000A7, 4'b0000, 6'h00, 8'hA7, 0));
    // all four requesting: rotation starts at ptr=1
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0010, 6'h02, 8'h11, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0100, 6'h04, 8'h12, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b1000, 6'h08, 8'h13, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0001, 6'h01, 8'h10, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0010, 6'h02, 8'h11, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0100, 6'h04, 8'h12, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b1000, 6'h08, 8'h13, 0));
    tbl.push_back(mk(0, 4'b1111, rr_a, rr_d, 4'b0001, 6'h01, 8'h10, 0));
    // grant 2 leaves ptr=3, then 3 wins over 0 and ptr wraps
    tbl.push_back(mk(0, 4'b0100, rr_a, rr_d, 4'b0100, 6'h04, 8'h12, 0));
    tbl.push_back(mk(0, 4'b1001, rr_a, rr_d, 4'b1000, 6'h08, 8'h13, 0));
    tbl.push_back(mk(0, 4'b1001, rr_a, rr_d, 4'b0001, 6'h01, 8'h10, 0));
    tbl.push_back(mk(0, 4'b0000, rr_a, rr_d, 4'b0000, 6'h00, 8'h10, 0));
    // hold blocks grants and keeps the bus
    tbl.push_back(mk(1, 4'b0010, 12'o0040, 32'h00003C00, 4'b0000, 6'h00, 8'h10, 0));
    tbl.push_back(mk(1, 4'b0010, 12'o0040, 32'h00003C00, 4'b0000, 6'h00, 8'h10, 0));
    tbl.push_back(mk(1, 4'b0010, 12'o0040, 32'h00003C00, 4'b0000, 6'h00, 8'h10, 0));
    tbl.push_back(mk(0, 4'b0010, 12'o0040, 32'h00003C00, 4'b0010, 6'h10, 8'h3C, 0));
    tbl.push_back(mk(0, 4'b0000, 12'o0040, 32'h00003C00, 4'b0000, 6'h00, 8'h3C, 0));
    // out-of-range addresses (7, then exactly NUM_REGS) are consumed with addr_err
    tbl.push_back(mk(0, 4'b0100, 12'o0700, 32'h00550000, 4'b0100, 6'h00, 8'h55, 1));
    tbl.push_back(mk(0, 4'b0000, 12'o0700, 32'h00550000, 4'b0000, 6'h00, 8'h55, 0));
    tbl.push_back(mk(0, 4'b1000, 12'o6000, 32'h66000000, 4'b1000, 6'h00, 8'h66, 1));
    tbl.push_back(mk(0, 4'b1000, 12'o5000, 32'h99000000, 4'b0000, 6'h00, 8'h66, 0));
    tbl.push_back(mk(0, 4'b1000, 12'o5000, 32'h99000000, 4'b1000, 6'h20, 8'h99, 0));
    tbl.push_back(mk(0, 4'b0000, 12'o5000, 32'h99000000, 4'b0000, 6'h00, 8'h99, 0));

    rst_n = 1'b0; hold = 1'b0; req = '0; req_addr = '0; req_data = '0;
    model_reset();
    #12;
    check_all("reset", 0, 4'b0000, 6'h00, 8'h00, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].h, tbl[i].r, tbl[i].a, tbl[i].d);
      check_all("vec", i, tbl[i].eg, tbl[i].el, tbl[i].eb, tbl[i].ee);
    end

    // asynchronous reset with a load to register 2 in flight
    cycle(0, 4'b0001, 12'o0002, 32'h0000005A);
    check_all("pre_rst", 0, 4'b0001, 6'h04, 8'h5A, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 4'b0000, 6'h00, 8'h00, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 4'b1111, rr_a, rr_d);
    check_all("post_rst", 0, 4'b0001, 6'h01, 8'h10, 1'b0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) == 0, 4'($urandom), 12'($urandom), $urandom);
      check_all("rand", n, m_grant, m_load, m_bus, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
